mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 138 +++++++++++++
 tb/tb_mem_responder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: captures one read/write request, waits a
// fixed number of cycles, pulses ready for one cycle, then waits for release.
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] address,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        ready,
  output logic        error,
  output logic        busy
);

  localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_RELEASE
  } state_t;

  state_t        state_reg, state_next;
  logic [3:0]    count_reg, count_next;
  logic          captured_reg;
  logic          is_write_reg;
  logic          err_reg;
  logic [AW-1:0] idx_reg;
  logic [31:0]   wdata_reg;
  logic [31:0]   data_out_reg;
  logic [31:0]   mem [DEPTH_WORDS];

  logic req;
  logic req_err;
  logic enter_done;

  assign req     = memRead | memWrite;
  assign req_err = (memRead & memWrite)
                 | (address[1:0] != 2'b00)
                 | ({2'b00, address[31:2]} >= 32'(DEPTH_WORDS));

  // The capture edge registers the request; the following edge launches it.
  // That extra IDLE cycle gives the total request-to-ready latency of WAIT_CYCLES+1.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      ST_IDLE: begin
        if (captured_reg) begin
          if (WAIT_CYCLES == 0) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_WAIT;
            count_next = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (count_reg == 4'd0) begin
          state_next = ST_DONE;
        end else begin
          count_next = count_reg - 4'd1;
        end
      end
      ST_DONE: begin
        state_next = ST_RELEASE;
        count_next = 4'd0;
      end
      ST_RELEASE: begin
        if (!req) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        count_next = 4'd0;
      end
    endcase
  end

  assign enter_done = (state_next == ST_DONE) && (state_reg != ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      count_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // Request capture: later changes on address/dataIn cannot reach the access.
  always_ff @(posedge clk) begin
    if (reset) begin
      captured_reg <= 1'b0;
      is_write_reg <= 1'b0;
      err_reg      <= 1'b0;
      idx_reg      <= '0;
      wdata_reg    <= '0;
    end else if ((state_reg == ST_IDLE) && !captured_reg && req) begin
      captured_reg <= 1'b1;
      is_write_reg <= memWrite;
      err_reg      <= req_err;
      idx_reg      <= address[AW+1:2];
      wdata_reg    <= dataIn;
    end else if ((state_reg == ST_IDLE) && captured_reg) begin
      captured_reg <= 1'b0;
    end
  end

  // Array write commits on the edge leaving DONE, unless reset lands on that edge.
  always_ff @(posedge clk) begin
    if (!reset && (state_reg == ST_DONE) && is_write_reg && !err_reg) begin
      mem[idx_reg] <= wdata_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_reg <= '0;
    end else if (enter_done && !is_write_reg && !err_reg) begin
      data_out_reg <= mem[idx_reg];
    end
  end

  assign dataOut = data_out_reg;
  assign ready   = (state_reg == ST_DONE);
  assign error   = (state_reg == ST_DONE) && err_reg;
  assign busy    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: timeline model checked every cycle on the
// WAIT_CYCLES=2 instance, plus directed literal checks on both instances.
module tb_mem_responder;

  localparam int DEPTH = 256;
  localparam int W     = 2;

  logic        clk = 1'b0;
  logic        reset, memRead, memWrite;
  logic [31:0] address, dataIn, dataOut;
  logic        ready, error, busy;

  logic        z_reset, z_rd, z_wr;
  logic [31:0] z_addr, z_din, z_dout;
  logic        z_ready, z_error, z_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite),
    .address(address), .dataIn(dataIn), .dataOut(dataOut),
    .ready(ready), .error(error), .busy(busy)
  );

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .reset(z_reset), .memRead(z_rd), .memWrite(z_wr),
    .address(z_addr), .dataIn(z_din), .dataOut(z_dout),
    .ready(z_ready), .error(z_error), .busy(z_busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // ---------------- behavioural timeline model ----------------
  int          cyc = 0;
  bit          m_valid = 0, accepting = 1, in_release = 0;
  int          done_at = -1, cap_edge = -1;
  bit          c_err, c_wr;
  int          c_idx;
  logic [31:0] c_data;
  logic [31:0] exp_dout;
  bit          dout_known;
  logic [31:0] mem_m [DEPTH];
  bit          known [DEPTH];

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_valid = 1; accepting = 1; in_release = 0; done_at = -1;
      exp_dout = '0; dout_known = 1;
    end else if (m_valid) begin
      if (in_release && !memRead && !memWrite) begin
        in_release = 0; accepting = 1;
      end
      if (done_at == cyc - 1) begin
        if (c_wr && !c_err) begin
          mem_m[c_idx] = c_data; known[c_idx] = 1;
        end
        in_release = 1;
      end else if (accepting && (memRead || memWrite)) begin
        accepting = 0;
        cap_edge  = cyc;
        done_at   = cyc + W + 1;
        c_wr      = memWrite;
        c_data    = dataIn;
        c_err     = (memRead && memWrite) || (address[1:0] != 2'b00) || (address[31:2] >= DEPTH);
        c_idx     = c_err ? 0 : int'(address[31:2]);
      end
      if (done_at == cyc && !c_wr && !c_err) begin
        exp_dout   = mem_m[c_idx];
        dout_known = known[c_idx];
      end
    end
    #1;
    if (m_valid) begin
      check("model ready", {31'b0, ready}, {31'b0, (done_at == cyc)});
      check("model error", {31'b0, error}, {31'b0, (done_at == cyc) && c_err});
      check("model busy", {31'b0, busy}, {31'b0, !accepting && (cyc >= cap_edge + 1)});
      if (dout_known) check("model dataOut", dataOut, exp_dout);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_ready(output int lat, output bit ok);
    lat = 0;
    ok  = 0;
    while (lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle timeout: busy=%b, expected 0", name, busy);
    end
  endtask

  // Called right after the capture edge; disturbs the inputs, then checks completion.
  task automatic finish_xact(input string name, input bit exp_err, input bit chk_d,
                             input logic [31:0] exp_d, input logic [31:0] a, input logic [31:0] d);
    int lat;
    bit ok;
    @(negedge clk);
    address = ~a;
    dataIn  = ~d;
    wait_ready(lat, ok);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s ready timeout: no ready within %0d cycles, expected 3", name, lat);
    end else begin
      check({name, " latency"}, lat, 3);
      check({name, " error"}, {31'b0, error}, {31'b0, exp_err});
      if (chk_d) check({name, " dataOut"}, dataOut, exp_d);
    end
    $display("xact %s addr=%08h data=%08h -> latency=%0d error=%b dataOut=%08h",
             name, a, d, lat, error, dataOut);
    @(posedge clk); #1;
    check({name, " ready width"}, {31'b0, ready}, 32'd0);
    @(negedge clk);
    memRead  = 1'b0;
    memWrite = 1'b0;
    wait_idle(name);
  endtask

  task automatic xact(input string name, input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input bit exp_err, input bit chk_d, input logic [31:0] exp_d);
    @(negedge clk);
    memRead = rd; memWrite = wr; address = a; dataIn = d;
    @(posedge clk);
    finish_xact(name, exp_err, chk_d, exp_d, a, d);
  endtask

  task automatic zxact(input string name, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input bit chk_d, input logic [31:0] exp_d);
    int lat;
    int n;
    @(negedge clk);
    z_rd = !wr; z_wr = wr; z_addr = a; z_din = d;
    @(posedge clk);
    lat = 0;
    while (lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (z_ready === 1'b1) break;
    end
    check({name, " latency"}, lat, 1);
    check({name, " error"}, {31'b0, z_error}, 32'd0);
    if (chk_d) check({name, " dataOut"}, z_dout, exp_d);
    $display("xact %s addr=%08h data=%08h -> latency=%0d error=%b dataOut=%08h",
             name, a, d, lat, z_error, z_dout);
    @(posedge clk); #1;
    check({name, " ready width"}, {31'b0, z_ready}, 32'd0);
    @(negedge clk);
    z_rd = 1'b0; z_wr = 1'b0;
    n = 0;
    while (z_busy !== 1'b0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " idle"}, {31'b0, z_busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int pulses;
    bit ok;
    reset = 1'b1; memRead = 1'b0; memWrite = 1'b0; address = '0; dataIn = '0;
    z_reset = 1'b1; z_rd = 1'b0; z_wr = 1'b0; z_addr = '0; z_din = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset dataOut", dataOut, 32'h0);
    check("reset ready", {31'b0, ready}, 32'd0);
    check("reset error", {31'b0, error}, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset z dataOut", z_dout, 32'h0);
    @(negedge clk);
    reset = 1'b0; z_reset = 1'b0;

    xact("w 0x00", 0, 1, 32'h0000_0000, 32'h1111_0000, 0, 0, '0);
    xact("w 0x10", 0, 1, 32'h0000_0010, 32'hCAFE_F00D, 0, 0, '0);
    xact("r 0x10", 1, 0, 32'h0000_0010, 32'h0, 0, 1, 32'hCAFE_F00D);
    xact("r 0x12 misaligned", 1, 0, 32'h0000_0012, 32'h0, 1, 1, 32'hCAFE_F00D);
    xact("w 0x400 out of range", 0, 1, 32'h0000_0400, 32'hDEAD_BEEF, 1, 1, 32'hCAFE_F00D);
    xact("r 0x00", 1, 0, 32'h0000_0000, 32'h0, 0, 1, 32'h1111_0000);
    xact("w 0x20", 0, 1, 32'h0000_0020, 32'hAAAA_0020, 0, 0, '0);
    xact("rw 0x20 conflict", 1, 1, 32'h0000_0020, 32'h5555_5555, 1, 1, 32'h1111_0000);
    xact("r 0x20", 1, 0, 32'h0000_0020, 32'h0, 0, 1, 32'hAAAA_0020);

    // Held read: exactly one completion, busy until the request drops.
    @(negedge clk);
    memRead = 1'b1; address = 32'h0000_0010;
    @(posedge clk);
    wait_ready(lat, ok);
    check("hold first ready", {31'b0, ok}, 32'd1);
    check("hold dataOut", dataOut, 32'hCAFE_F00D);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ready) pulses++;
    end
    check("hold extra ready pulses", pulses, 0);
    check("hold busy", {31'b0, busy}, 32'd1);
    $display("xact hold r 0x10 -> latency=%0d extra_pulses=%0d busy=%b", lat, pulses, busy);
    @(negedge clk);
    memRead = 1'b0;
    @(posedge clk); #1;
    check("release busy", {31'b0, busy}, 32'd0);
    xact("r 0x00 after release", 1, 0, 32'h0000_0000, 32'h0, 0, 1, 32'h1111_0000);

    // Reset in the middle of WAIT for a write.
    xact("w 0x30", 0, 1, 32'h0000_0030, 32'h0BAD_BEEF, 0, 0, '0);
    @(negedge clk);
    memWrite = 1'b1; address = 32'h0000_0030; dataIn = 32'h1234_5678;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; memWrite = 1'b0;
    @(posedge clk); #1;
    check("wait-reset busy", {31'b0, busy}, 32'd0);
    check("wait-reset dataOut", dataOut, 32'h0);
    check("wait-reset ready", {31'b0, ready}, 32'd0);
    $display("xact reset during WAIT of w 0x30 -> busy=%b dataOut=%08h", busy, dataOut);
    @(negedge clk);
    reset = 1'b0;
    xact("r 0x30", 1, 0, 32'h0000_0030, 32'h0, 0, 1, 32'h0BAD_BEEF);

    // Reset landing on the edge that would commit a write.
    xact("w 0x34", 0, 1, 32'h0000_0034, 32'h0000_0077, 0, 0, '0);
    @(negedge clk);
    memWrite = 1'b1; address = 32'h0000_0034; dataIn = 32'h0000_0099;
    @(posedge clk);
    wait_ready(lat, ok);
    check("done-reset saw ready", {31'b0, ok}, 32'd1);
    @(negedge clk);
    reset = 1'b1; memWrite = 1'b0;
    @(posedge clk); #1;
    check("done-reset busy", {31'b0, busy}, 32'd0);
    $display("xact reset during DONE of w 0x34 -> busy=%b", busy);
    @(negedge clk);
    reset = 1'b0;
    xact("r 0x34", 1, 0, 32'h0000_0034, 32'h0, 0, 1, 32'h0000_0077);

    // Request already held when reset is released.
    @(negedge clk);
    reset = 1'b1; memRead = 1'b1; address = 32'h0000_0010;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    finish_xact("r 0x10 held over reset", 0, 1, 32'hCAFE_F00D, 32'h0000_0010, 32'h0);

    // Zero-wait-state instance.
    zxact("z w 0x08", 1, 32'h0000_0008, 32'h55AA_1234, 0, '0);
    zxact("z r 0x08", 0, 32'h0000_0008, 32'h0, 1, 32'h55AA_1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
